interlock_packet_receiver: RTL and testbench



---
 rtl/interlock_pkg.sv | 41 ++++
 rtl/sysmon_shadow_ram.sv | 40 ++++
 rtl/interlock_packet_receiver.sv | 143 ++++++++++++++
 tb/tb_interlock_packet_receiver.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/interlock_pkg.sv
// Field layout, sizing constants and link-state encoding for the local interlock packet.
// Shared by the packet source and the receiver so both ends agree on the layout.
package interlock_pkg;

    localparam int DATA_WIDTH        = 160;
    localparam int INTERLOCK_COUNT   = 64;
    localparam int SYSMON_ADDR_WIDTH = 7;
    localparam int SYSMON_DATA_WIDTH = 16;
    localparam int CLK_PERIOD_PS     = 3200;
    localparam int TIMEOUT_NS        = 1000;
    localparam int TIMEOUT_TICKS     = TIMEOUT_NS * 1000 / CLK_PERIOD_PS;
    localparam int WD_WIDTH          = $clog2(TIMEOUT_TICKS);
    localparam int PAD_WIDTH         = 16 - 1 - SYSMON_ADDR_WIDTH;

    localparam int STATE_LSB = 96;
    localparam int TRANS_LSB = 32;
    localparam int FLAG_BIT  = 31;
    localparam int PAD_LSB   = 23;
    localparam int ADDR_LSB  = 16;
    localparam int DATA_LSB  = 0;

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        UP         = 2'd1,
        TIMED_OUT  = 2'd2
    } link_state_t;

    typedef struct packed {
        logic [INTERLOCK_COUNT-1:0]   state;
        logic [INTERLOCK_COUNT-1:0]   transitions;
        logic                         flag;
        logic [PAD_WIDTH-1:0]         pad;
        logic [SYSMON_ADDR_WIDTH-1:0] addr;
        logic [SYSMON_DATA_WIDTH-1:0] data;
    } packet_t;

    function automatic logic packet_format_ok(input packet_t p);
        return (p.pad == '0) && (p.flag == (|p.transitions));
    endfunction

endpackage

// File: rtl/sysmon_shadow_ram.sv
// Shadow copy of system-monitor readings: simple dual-port, one write, one registered read.
// Read returns pre-write contents on a same-cycle address collision; array itself is never reset.
module sysmon_shadow_ram #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_d;
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_comb begin
        rd_d = mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd_dat = rd_q;

endmodule

// File: rtl/interlock_packet_receiver.sv
// Validates toggle-strobed interlock packets, publishes state, sticky history and sysmon shadow.
// Outputs update on the 3rd clk edge after a toggle; a link watchdog flags packet loss.
module interlock_packet_receiver
    import interlock_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rxToggle,
    input  logic [DATA_WIDTH-1:0]        rxData,
    input  logic                         stickyClear,
    input  logic [SYSMON_ADDR_WIDTH-1:0] sysmonReadAddr,
    output logic [INTERLOCK_COUNT-1:0]   inputState,
    output logic                         inputStateValid,
    output logic [INTERLOCK_COUNT-1:0]   stickyTransitions,
    output logic                         transitionEvent,
    output logic [SYSMON_DATA_WIDTH-1:0] sysmonReadData,
    output logic                         linkTimeout,
    output logic [15:0]                  addrSkipCount,
    output logic [7:0]                   formatErrorCount,
    output logic [31:0]                  packetCount
);

    localparam logic [WD_WIDTH-1:0] WD_RELOAD = WD_WIDTH'(TIMEOUT_TICKS - 1);

    logic sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;
    link_state_t state_q, state_d;
    logic [WD_WIDTH-1:0]          wd_q, wd_d;
    logic [INTERLOCK_COUNT-1:0]   in_state_q, in_state_d;
    logic [INTERLOCK_COUNT-1:0]   sticky_q, sticky_d;
    logic                         event_q, event_d;
    logic [SYSMON_ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [15:0]                  skip_q, skip_d;
    logic [7:0]                   fmt_err_q, fmt_err_d;
    logic [31:0]                  pkt_cnt_q, pkt_cnt_d;

    packet_t pkt;
    logic    strobe;
    logic    accept;
    logic    reject;

    always_comb begin
        pkt     = packet_t'(rxData);
        sync1_d = rxToggle;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
        strobe  = sync2_q ^ dly_q;
        accept  = strobe & packet_format_ok(pkt);
        reject  = strobe & ~packet_format_ok(pkt);
    end

    // Acceptance wins over an expiring watchdog in the same cycle.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        if (accept) begin
            state_d = UP;
            wd_d    = WD_RELOAD;
        end else begin
            if (wd_q != '0) begin
                wd_d = wd_q - 1'b1;
            end else if (state_q != TIMED_OUT) begin
                state_d = TIMED_OUT;
            end
        end
    end

    always_comb begin
        in_state_d  = in_state_q;
        sticky_d    = stickyClear ? '0 : sticky_q;
        event_d     = 1'b0;
        last_addr_d = last_addr_q;
        skip_d      = skip_q;
        fmt_err_d   = fmt_err_q;
        pkt_cnt_d   = pkt_cnt_q;
        if (accept) begin
            in_state_d  = pkt.state;
            sticky_d    = sticky_d | pkt.transitions;
            event_d     = pkt.flag;
            last_addr_d = pkt.addr;
            pkt_cnt_d   = pkt_cnt_q + 32'd1;
            // Continuity only judged while the link is already UP.
            if ((state_q == UP) && (pkt.addr != last_addr_q + 1'b1) && (skip_q != 16'hFFFF)) begin
                skip_d = skip_q + 16'd1;
            end
        end
        if (reject && (fmt_err_q != 8'hFF)) begin
            fmt_err_d = fmt_err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            dly_q       <= 1'b0;
            state_q     <= RESET_WAIT;
            wd_q        <= WD_RELOAD;
            in_state_q  <= '0;
            sticky_q    <= '0;
            event_q     <= 1'b0;
            last_addr_q <= '0;
            skip_q      <= '0;
            fmt_err_q   <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            dly_q       <= dly_d;
            state_q     <= state_d;
            wd_q        <= wd_d;
            in_state_q  <= in_state_d;
            sticky_q    <= sticky_d;
            event_q     <= event_d;
            last_addr_q <= last_addr_d;
            skip_q      <= skip_d;
            fmt_err_q   <= fmt_err_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    sysmon_shadow_ram #(
        .ADDR_WIDTH (SYSMON_ADDR_WIDTH),
        .DATA_WIDTH (SYSMON_DATA_WIDTH)
    ) u_shadow_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (pkt.addr),
        .wr_dat  (pkt.data),
        .rd_addr (sysmonReadAddr),
        .rd_dat  (sysmonReadData)
    );

    assign inputState        = in_state_q;
    assign inputStateValid   = (state_q == UP);
    assign stickyTransitions = sticky_q;
    assign transitionEvent   = event_q;
    assign linkTimeout       = (state_q == TIMED_OUT);
    assign addrSkipCount     = skip_q;
    assign formatErrorCount  = fmt_err_q;
    assign packetCount       = pkt_cnt_q;

endmodule

// File: tb/tb_interlock_packet_receiver.sv
// Randomized bench for interlock_packet_receiver against a cycle-counting behavioural model.
module tb_interlock_packet_receiver;

    localparam int TICKS = 1000 * 1000 / 3200;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rxToggle = 1'b0;
    logic [159:0] rxData = '0;
    logic         stickyClear = 1'b0;
    logic [6:0]   sysmonReadAddr = '0;
    logic [63:0]  inputState;
    logic         inputStateValid;
    logic [63:0]  stickyTransitions;
    logic         transitionEvent;
    logic [15:0]  sysmonReadData;
    logic         linkTimeout;
    logic [15:0]  addrSkipCount;
    logic [7:0]   formatErrorCount;
    logic [31:0]  packetCount;

    interlock_packet_receiver dut (
        .clk               (clk),
        .rst               (rst),
        .rxToggle          (rxToggle),
        .rxData            (rxData),
        .stickyClear       (stickyClear),
        .sysmonReadAddr    (sysmonReadAddr),
        .inputState        (inputState),
        .inputStateValid   (inputStateValid),
        .stickyTransitions (stickyTransitions),
        .transitionEvent   (transitionEvent),
        .sysmonReadData    (sysmonReadData),
        .linkTimeout       (linkTimeout),
        .addrSkipCount     (addrSkipCount),
        .formatErrorCount  (formatErrorCount),
        .packetCount       (packetCount)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: m_e counts clock edges since the last acceptance (or reset release).
    logic [63:0] m_state, m_sticky;
    logic        m_ev;
    int          m_pkt, m_err, m_skip, m_e;
    logic [6:0]  m_last;
    bit          m_have;
    logic [15:0] shadow [128];
    bit          sh_vld [128];
    logic [15:0] m_rd;
    bit          m_rd_known;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("inputState", inputState, m_state);
        chk("inputStateValid", 64'(inputStateValid), 64'(m_have && (m_e < TICKS)));
        chk("stickyTransitions", stickyTransitions, m_sticky);
        chk("transitionEvent", 64'(transitionEvent), 64'(m_ev));
        chk("linkTimeout", 64'(linkTimeout), 64'(m_e >= TICKS));
        chk("addrSkipCount", 64'(addrSkipCount), 64'(m_skip));
        chk("formatErrorCount", 64'(formatErrorCount), 64'(m_err));
        chk("packetCount", 64'(packetCount), 64'(m_pkt));
        if (m_rd_known) chk("sysmonReadData", 64'(sysmonReadData), 64'(m_rd));
    endtask

    task automatic tick();
        @(posedge clk);
        m_e++;
        m_ev       = 1'b0;
        m_rd       = shadow[sysmonReadAddr];
        m_rd_known = sh_vld[sysmonReadAddr];
    endtask

    task automatic capture(input bit clr);
        logic [63:0] st, tr;
        logic        fl;
        logic [7:0]  pad;
        logic [6:0]  ad, nx;
        logic [15:0] dt;
        bit          ok;
        st  = rxData[159:96];
        tr  = rxData[95:32];
        fl  = rxData[31];
        pad = rxData[30:23];
        ad  = rxData[22:16];
        dt  = rxData[15:0];
        ok  = (pad == 8'd0) && (fl == (tr != 64'd0));
        @(posedge clk);
        m_rd       = shadow[sysmonReadAddr];
        m_rd_known = sh_vld[sysmonReadAddr];
        if (clr) m_sticky = '0;
        if (ok) begin
            nx = m_last + 7'd1;
            if (m_have && (m_e < TICKS) && (ad != nx) && (m_skip < 65535)) m_skip++;
            m_have     = 1'b1;
            m_e        = 0;
            m_state    = st;
            m_sticky   = m_sticky | tr;
            m_ev       = fl;
            shadow[ad] = dt;
            sh_vld[ad] = 1'b1;
            m_pkt++;
            m_last     = ad;
        end else begin
            m_e++;
            m_ev = 1'b0;
            if (m_err < 255) m_err++;
        end
        #1;
        stickyClear = 1'b0;
        compare_all();
    endtask

    task automatic send(input logic [63:0] st, input logic [63:0] tr, input logic fl,
                        input logic [7:0] pad, input logic [6:0] ad, input logic [15:0] dt,
                        input bit clr);
        @(negedge clk);
        rxData   = {st, tr, fl, pad, ad, dt};
        rxToggle = ~rxToggle;
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        stickyClear = clr;
        capture(clr);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
        #1;
        compare_all();
    endtask

    task automatic rd(input logic [6:0] ad);
        @(negedge clk);
        sysmonReadAddr = ad;
        tick();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_state = '0; m_sticky = '0; m_ev = 1'b0;
        m_pkt = 0; m_err = 0; m_skip = 0; m_e = 0;
        m_last = '0; m_have = 1'b0;
        m_rd = '0; m_rd_known = 1'b1;
        compare_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // A toggle left high across reset release is seen as one new packet.
        if (rxToggle) begin
            tick();
            @(negedge clk);
            tick();
            @(negedge clk);
            capture(1'b0);
        end
    endtask

    initial begin
        logic [63:0] st, tr;
        logic        fl;
        logic [7:0]  pad;
        logic [6:0]  ad;
        int          mode;

        for (int i = 0; i < 128; i++) begin
            shadow[i] = '0;
            sh_vld[i] = 1'b0;
        end
        do_reset();

        send(64'hFEDCBA9876543210, 64'h0, 1'b0, 8'h00, 7'd0, 16'h1111, 1'b0);
        rd(7'd0);
        send(64'h1, 64'h1, 1'b1, 8'h00, 7'd1, 16'h2222, 1'b0);
        send(64'h2, 64'h2, 1'b1, 8'h00, 7'd2, 16'h3333, 1'b1);
        send(64'hDEAD, 64'h0, 1'b1, 8'h00, 7'd9, 16'h4444, 1'b0);
        send(64'h3, 64'h0, 1'b0, 8'h00, 7'd3, 16'h0003, 1'b0);
        send(64'h4, 64'h0, 1'b0, 8'h00, 7'd4, 16'h0004, 1'b0);
        send(64'h5, 64'h0, 1'b0, 8'h00, 7'd5, 16'h0005, 1'b0);
        send(64'h6, 64'h0, 1'b0, 8'h00, 7'd6, 16'h0006, 1'b0);
        send(64'h8, 64'h0, 1'b0, 8'h00, 7'd8, 16'hABCD, 1'b0);
        rd(7'd8);
        send(64'h9, 64'h0, 1'b0, 8'h00, 7'd8, 16'h5678, 1'b0);
        rd(7'd8);

        idle(TICKS - 1);
        idle(1);
        send(64'h40, 64'h0, 1'b0, 8'h00, 7'd40, 16'h0040, 1'b0);

        @(negedge clk);
        rxData   = {64'hCAFE, 64'h0, 1'b0, 8'h00, 7'd77, 16'h7777};
        rxToggle = ~rxToggle;
        tick();
        do_reset();
        send(64'h55, 64'h0, 1'b0, 8'h00, 7'd100, 16'h0100, 1'b0);

        for (int i = 0; i < 60; i++) begin
            st   = {$urandom, $urandom};
            tr   = ($urandom_range(0, 1) == 0) ? 64'h0 : {$urandom, $urandom};
            fl   = (tr != 64'h0);
            pad  = 8'h00;
            mode = $urandom_range(0, 9);
            if (mode == 0) pad = 8'($urandom_range(1, 255));
            if (mode == 1) fl = ~fl;
            ad   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : m_last + 7'd1;
            send(st, tr, fl, pad, ad, 16'($urandom), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 19) == 0) idle(TICKS + 8);
            else idle($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) rd(ad);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
